// File: rtl/blinds_motor_ctrl.sv
// Blinds motor controller: steps the up/down motor one level at a time toward the target level.
// Optional homing sequence at reset is built in when BLINDS_HOME_EN is defined.
module blinds_motor_ctrl #(
    parameter int unsigned STEP_CYCLES   = 8,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
`ifdef BLINDS_HOME_EN
    input  logic       home_sw,
`endif
    input  logic [1:0] target,
    input  logic       enable,
    output logic       motor_down,
    output logic       motor_up,
    output logic [1:0] position,
    output logic       busy,
    output logic       at_target
);

    localparam int unsigned CNT_W = $clog2(4 * STEP_CYCLES + SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] STEP_LAST   = CNT_W'(STEP_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

`ifdef BLINDS_HOME_EN
    localparam logic [CNT_W-1:0] HOME_LAST = CNT_W'(4 * STEP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        MOVE_DOWN = 3'd1,
        MOVE_UP   = 3'd2,
        DEAD      = 3'd3,
        HOMING    = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVE_DOWN = 2'd1,
        MOVE_UP   = 2'd2,
        DEAD      = 2'd3
    } state_t;
`endif

    state_t           state_q;
    state_t           state_d;
    state_t           step_dir;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [1:0]       pos_d;
    logic             motor_down_d;
    logic             motor_up_d;
    logic             busy_d;

    // Direction needed to reach the target from a given level, or IDLE when none.
    function automatic state_t decide(input logic [1:0] pos, input logic [1:0] tgt,
                                      input logic en);
        if (en && (tgt > pos)) begin
            return MOVE_DOWN;
        end else if (en && (tgt < pos)) begin
            return MOVE_UP;
        end
        return IDLE;
    endfunction

    // Next-state, counter, position and output decode.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pos_d    = position;
        step_dir = IDLE;

        case (state_q)
            IDLE: begin
                cnt_d   = '0;
                state_d = decide(position, target, enable);
            end
            MOVE_DOWN, MOVE_UP: begin
                if (cnt_q == STEP_LAST) begin
                    cnt_d    = '0;
                    pos_d    = (state_q == MOVE_DOWN) ? position + 2'd1 : position - 2'd1;
                    step_dir = decide(pos_d, target, enable);
                    // Reversal must pass through dead time, never straight across.
                    if (step_dir == IDLE) begin
                        state_d = IDLE;
                    end else if (step_dir == state_q) begin
                        state_d = state_q;
                    end else begin
                        state_d = DEAD;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            DEAD: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = '0;
                    state_d = decide(position, target, enable);
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
`ifdef BLINDS_HOME_EN
            HOMING: begin
                if (home_sw || (cnt_q == HOME_LAST)) begin
                    cnt_d   = '0;
                    pos_d   = 2'd0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
`endif
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase

`ifdef BLINDS_HOME_EN
        // End-stop contact means the blind is physically fully open.
        if (home_sw) begin
            pos_d = 2'd0;
        end
        motor_up_d = (state_d == MOVE_UP) || (state_d == HOMING);
`else
        motor_up_d = (state_d == MOVE_UP);
`endif
        motor_down_d = (state_d == MOVE_DOWN);
        busy_d       = (state_d != IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            position   <= 2'd0;
            motor_down <= 1'b0;
`ifdef BLINDS_HOME_EN
            state_q    <= HOMING;
            motor_up   <= 1'b1;
            busy       <= 1'b1;
`else
            state_q    <= IDLE;
            motor_up   <= 1'b0;
            busy       <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            position   <= pos_d;
            motor_down <= motor_down_d;
            motor_up   <= motor_up_d;
            busy       <= busy_d;
        end
    end

    // Reflects the live target so the status follows the level-decision stage immediately.
    assign at_target = (state_q == IDLE) && (position == target);

endmodule
